// File: rtl/mac_seq_pkg.sv
// Shared types and sizing for the MAC sequencing controller.
// Used by the controller, its bus interface and the optional watchdog (MAC_SEQ_TIMEOUT_EN).
package mac_seq_pkg;

  localparam int LEN_W      = 8;
  localparam int OP_W       = 8;
  localparam int ACC_W      = 16;
  localparam int WDOG_LIMIT = 255;
  localparam int WDOG_W     = 8;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    DRAIN,
    RESULT
  } state_e;

endpackage

// File: rtl/mac_seq_ctrl_if.sv
// Bundles the job-control, operand, result and MAC-datapath signals of mac_seq_ctrl.
// The controller uses the slave modport; the environment (bench or MAC wrapper) uses master.
interface mac_seq_ctrl_if;
  import mac_seq_pkg::*;

  logic             start;
  logic [LEN_W-1:0] len;
  logic             abort;
  logic             busy;

  logic             op_valid;
  logic             op_ready;
  logic [OP_W-1:0]  op_a;
  logic [OP_W-1:0]  op_b;

  logic             res_valid;
  logic             res_ready;
  logic [ACC_W-1:0] res_data;
  logic             timeout;

  logic             mac_clr;
  logic             mac_acc_en;
  logic [OP_W-1:0]  mac_a;
  logic [OP_W-1:0]  mac_b;
  logic [ACC_W-1:0] mac_acc;

  modport slave (
    input  start, len, abort, op_valid, op_a, op_b, res_ready, mac_acc,
    output busy, op_ready, res_valid, res_data, timeout,
           mac_clr, mac_acc_en, mac_a, mac_b
  );

  modport master (
    output start, len, abort, op_valid, op_a, op_b, res_ready, mac_acc,
    input  busy, op_ready, res_valid, res_data, timeout,
           mac_clr, mac_acc_en, mac_a, mac_b
  );

endinterface

// File: rtl/mac_seq_wdog.sv
// Stall watchdog for the RUN phase: counts consecutive cycles without an operand handshake.
// Only instantiated when MAC_SEQ_TIMEOUT_EN is defined.
module mac_seq_wdog
  import mac_seq_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic run_i,
  input  logic hs_i,
  output logic expire_o
);

  logic [WDOG_W-1:0] count_q, count_d;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    count_d = count_q;
    if (!run_i || hs_i) begin
      count_d = '0;
    end else if (count_q != WDOG_W'(WDOG_LIMIT)) begin
      count_d = count_q + 1'b1;
    end
  end

  // The current idle cycle is the one that brings the count to the limit.
  assign expire_o = run_i && !hs_i && (count_q == WDOG_W'(WDOG_LIMIT - 1));

  // NOTE: state registers use non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mac_seq_ctrl.sv
// Job sequencer for an external multiply-accumulate datapath: clear, stream N operand pairs, return the sum.
// Define MAC_SEQ_TIMEOUT_EN to add a RUN-phase stall watchdog that ends the job with timeout=1.
module mac_seq_ctrl
  import mac_seq_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  mac_seq_ctrl_if.slave  bus
);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [ACC_W-1:0] res_q, res_d;
  logic             to_q, to_d;
  logic             hs;
  logic             wdog_expire;

  // Abort and reset both veto the handshake so the MAC never accumulates in those cycles.
  assign hs = (state_q == RUN) && bus.op_valid && !bus.abort && !rst;

`ifdef MAC_SEQ_TIMEOUT_EN
  mac_seq_wdog u_wdog (
    .clk      (clk),
    .rst      (rst),
    .run_i    (state_q == RUN),
    .hs_i     (hs),
    .expire_o (wdog_expire)
  );
`else
  assign wdog_expire = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    res_d   = res_q;
    to_d    = to_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          to_d = 1'b0;
          if (bus.len == '0) begin
            res_d   = '0;
            state_d = RESULT;
          end else begin
            rem_d   = bus.len;
            state_d = CLEAR;
          end
        end
      end
      CLEAR: state_d = RUN;
      RUN: begin
        if (hs) begin
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d = DRAIN;
          end
        end else if (wdog_expire) begin
          to_d    = 1'b1;
          state_d = DRAIN;
        end
      end
      // The last accumulate lands on the edge entering DRAIN, so mac_acc is final here.
      DRAIN: begin
        res_d   = bus.mac_acc;
        state_d = RESULT;
      end
      RESULT: begin
        if (bus.res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (bus.abort) begin
      state_d = IDLE;
      rem_d   = '0;
      to_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      res_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      res_q   <= res_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    bus.busy       = (state_q != IDLE);
    bus.mac_clr    = (state_q == CLEAR) && !rst;
    bus.op_ready   = (state_q == RUN) && !bus.abort && !rst;
    bus.mac_acc_en = hs;
    bus.mac_a      = hs ? bus.op_a : '0;
    bus.mac_b      = hs ? bus.op_b : '0;
    bus.res_valid  = (state_q == RESULT) && !bus.abort && !rst;
    bus.res_data   = res_q;
    bus.timeout    = to_q && !rst;
  end

endmodule
